// File: rtl/ft_pkg.sv
// Shared FT600/601 245-sync FIFO definitions for the RX and TX paths.
package ft_pkg;

  localparam int unsigned FT_DATA_W = 32;
  localparam int unsigned FT_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    OE,
    READ,
    TURN
  } rx_state_t;

  typedef struct packed {
    logic [FT_DATA_W-1:0] data;
    logic [FT_BE_W-1:0]   be;
  } ft_word_t;

endpackage

// File: rtl/ft_rx_ctrl_if.sv
// FTDI read-side pins plus downstream valid/ready stream for ft_rx_ctrl.
interface ft_rx_ctrl_if;

  logic                         iRXF_N;
  logic [ft_pkg::FT_DATA_W-1:0] iDATA;
  logic [ft_pkg::FT_BE_W-1:0]   iBE;
  logic                         oOE_N;
  logic                         oRD_N;
  logic                         iGRANT;
  logic                         oBUSY;
  logic [ft_pkg::FT_DATA_W-1:0] oDATA;
  logic [ft_pkg::FT_BE_W-1:0]   oBE;
  logic                         oVALID;
  logic                         iREADY;
  logic [15:0]                  oRX_CNT;

  modport master (
    input  iRXF_N, iDATA, iBE, iGRANT, iREADY,
    output oOE_N, oRD_N, oBUSY, oDATA, oBE, oVALID, oRX_CNT
  );

  modport slave (
    output iRXF_N, iDATA, iBE, iGRANT, iREADY,
    input  oOE_N, oRD_N, oBUSY, oDATA, oBE, oVALID, oRX_CNT
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is visible whenever not empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // Head forced to zero while empty so the output is defined straight out of reset.
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ft_rx_ctrl.sv
// FT600/601 245-sync read master: strobes OE_N/RD_N, captures words into a FWFT FIFO.
module ft_rx_ctrl
  import ft_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic            iCLK,
  input  logic            iRESET,
  ft_rx_ctrl_if.master    bus
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]   AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST);

  rx_state_t          state, state_nx;
  logic               oe_n_nx, rd_n_nx;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nx;
  logic [CNT_W-1:0]   fill, fill_nx;
  logic               capture, pop, empty, full;
  ft_word_t           head;

  assign capture = !bus.oRD_N && !bus.iRXF_N;
  assign pop     = bus.iREADY && !empty;

  always_comb begin
    fill_nx = fill;
    if (capture && !pop)      fill_nx = fill + 1'b1;
    else if (!capture && pop) fill_nx = fill - 1'b1;
  end

  always_comb begin
    state_nx     = state;
    oe_n_nx      = 1'b1;
    rd_n_nx      = 1'b1;
    burst_cnt_nx = burst_cnt;
    unique case (state)
      IDLE: begin
        if (!bus.iRXF_N && bus.iGRANT && !full && fill < AF_LEVEL) begin
          state_nx     = OE;
          oe_n_nx      = 1'b0;
          burst_cnt_nx = '0;
        end
      end
      OE: begin
        if (!bus.iGRANT) begin
          state_nx = TURN;
        end else begin
          state_nx = READ;
          oe_n_nx  = 1'b0;
          rd_n_nx  = 1'b0;
        end
      end
      READ: begin
        if (capture) burst_cnt_nx = burst_cnt + 1'b1;
        // The word taken on the stopping edge is kept; RD_N high afterwards blocks the next one.
        if (bus.iRXF_N || fill_nx >= AF_LEVEL || burst_cnt_nx == BURST_LAST || !bus.iGRANT) begin
          state_nx = TURN;
        end else begin
          oe_n_nx = 1'b0;
          rd_n_nx = 1'b0;
        end
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state       <= IDLE;
      bus.oOE_N   <= 1'b1;
      bus.oRD_N   <= 1'b1;
      burst_cnt   <= '0;
      bus.oRX_CNT <= '0;
    end else begin
      state     <= state_nx;
      bus.oOE_N <= oe_n_nx;
      bus.oRD_N <= rd_n_nx;
      burst_cnt <= burst_cnt_nx;
      if (capture) bus.oRX_CNT <= bus.oRX_CNT + 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (FT_DATA_W + FT_BE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRESET),
    .push  (capture),
    .din   ({bus.iDATA, bus.iBE}),
    .pop   (bus.iREADY),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (fill)
  );

  assign bus.oBUSY  = (state != IDLE);
  assign bus.oDATA  = head.data;
  assign bus.oBE    = head.be;
  assign bus.oVALID = !empty;

endmodule

// File: tb/tb_ft_rx_ctrl.sv
// Directed bench for ft_rx_ctrl with a simple FT60x read-side imitator.
module tb_ft_rx_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ft_rx_ctrl_if bus();

  ft_rx_ctrl #(
    .DEPTH     (16),
    .AF_MARGIN (2),
    .MAX_BURST (8)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // FTDI imitator: RXF_N low while words remain; a word is consumed on every RD_N-low edge.
  logic [35:0] src_mem [256];
  int unsigned src_wr = 0;
  int unsigned src_rd = 0;
  assign bus.iRXF_N = (src_rd == src_wr);
  assign bus.iDATA  = src_mem[src_rd[7:0]][35:4];
  assign bus.iBE    = src_mem[src_rd[7:0]][3:0];
  always @(posedge clk) if (!bus.oRD_N && !bus.iRXF_N) src_rd <= src_rd + 1;

  logic [35:0] rx_log [64];
  int unsigned rx_n  = 0;
  int unsigned cap_n = 0;
  always @(posedge clk) begin
    if (!rst && bus.oVALID && bus.iREADY) begin
      rx_log[rx_n[5:0]] = {bus.oDATA, bus.oBE};
      rx_n++;
    end
    if (!rst && !bus.oRD_N && !bus.iRXF_N) cap_n++;
    if (!rst && dut.u_fifo.push && dut.u_fifo.full) begin
      errors++;
      $display("FAIL fifo_overflow: push=1 full=1 at %0t, required no push into full FIFO", $time);
    end
  end

  task automatic put(input logic [31:0] d, input logic [3:0] be);
    src_mem[src_wr[7:0]] = {d, be};
    src_wr++;
  endtask

  task automatic wait_drain(output bit timed_out);
    int n = 0;
    while ((src_rd != src_wr || bus.oBUSY || bus.oVALID) && n < 500) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 500);
  endtask

  task automatic wait_rd_low(output bit timed_out);
    int n = 0;
    while (bus.oRD_N && n < 50) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 50);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.oOE_N, bus.oRD_N, bus.oBUSY, bus.oVALID} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ctrl: oe/rd/busy/valid=%b required 1100",
               {bus.oOE_N, bus.oRD_N, bus.oBUSY, bus.oVALID});
    end
    checks++;
    if ({bus.oDATA, bus.oBE} !== 36'h0) begin
      errors++;
      $display("FAIL reset_head: data/be=%h required 0", {bus.oDATA, bus.oBE});
    end
    checks++;
    if (bus.oRX_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: rx_cnt=%0d required 0", bus.oRX_CNT);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_burst;
    logic [3:0]  exp_sig [8];
    logic [15:0] cnt0;
    int unsigned cap0;
    bit          to;
    exp_sig = '{4'b0110, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1110, 4'b1100};
    rx_n = 0;
    cap0 = cap_n;
    cnt0 = bus.oRX_CNT;
    for (int i = 0; i < 4; i++) put(32'hA0A0_0000 + 32'(i), 4'hF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.oOE_N, bus.oRD_N, bus.oBUSY, bus.oVALID} !== exp_sig[k]) begin
        errors++;
        $display("FAIL single_seq[%0d]: oe/rd/busy/valid=%b required %b", k,
                 {bus.oOE_N, bus.oRD_N, bus.oBUSY, bus.oVALID}, exp_sig[k]);
      end
    end
    wait_drain(to);
    checks++;
    if (to || rx_n !== 4 || cap_n - cap0 !== 4) begin
      errors++;
      $display("FAIL single_count: popped=%0d captured=%0d timeout=%0b required 4/4/0",
               rx_n, cap_n - cap0, to);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_log[i] !== {32'hA0A0_0000 + 32'(i), 4'hF}) begin
        errors++;
        $display("FAIL single_word[%0d]: got %h required %h", i, rx_log[i],
                 {32'hA0A0_0000 + 32'(i), 4'hF});
      end
    end
    checks++;
    if (16'(bus.oRX_CNT - cnt0) !== 16'd4) begin
      errors++;
      $display("FAIL single_rx_cnt: delta=%0d required 4", 16'(bus.oRX_CNT - cnt0));
    end
  endtask

  task automatic test_partial_be;
    bit to;
    rx_n = 0;
    put(32'h1111_2222, 4'hF);
    put(32'h3333_4444, 4'b1100);
    put(32'h0000_BEEF, 4'b0011);
    wait_drain(to);
    checks++;
    if (to || rx_n !== 3) begin
      errors++;
      $display("FAIL pbe_count: popped=%0d timeout=%0b required 3/0", rx_n, to);
    end
    checks++;
    if (rx_log[1] !== {32'h3333_4444, 4'b1100}) begin
      errors++;
      $display("FAIL pbe_mid: got %h required %h", rx_log[1], {32'h3333_4444, 4'b1100});
    end
    checks++;
    if (rx_log[2] !== {32'h0000_BEEF, 4'b0011}) begin
      errors++;
      $display("FAIL pbe_last: got %h required %h", rx_log[2], {32'h0000_BEEF, 4'b0011});
    end
  endtask

  task automatic test_grant_oe_abort;
    int unsigned cap0;
    bit          to;
    rx_n = 0;
    cap0 = cap_n;
    for (int i = 0; i < 3; i++) put(32'hC0C0_0000 + 32'(i), 4'hF);
    @(negedge clk);
    checks++;
    if ({bus.oOE_N, bus.oRD_N} !== 2'b01) begin
      errors++;
      $display("FAIL oeabort_oe: oe/rd=%b required 01", {bus.oOE_N, bus.oRD_N});
    end
    bus.iGRANT = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.oOE_N, bus.oRD_N, bus.oBUSY} !== 3'b111 || cap_n != cap0) begin
      errors++;
      $display("FAIL oeabort_turn: oe/rd/busy=%b captured=%0d required 111/0",
               {bus.oOE_N, bus.oRD_N, bus.oBUSY}, cap_n - cap0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.oOE_N, bus.oBUSY} !== 2'b10 || cap_n != cap0) begin
      errors++;
      $display("FAIL oeabort_hold: oe/busy=%b captured=%0d required 10/0",
               {bus.oOE_N, bus.oBUSY}, cap_n - cap0);
    end
    bus.iGRANT = 1'b1;
    wait_drain(to);
    checks++;
    if (to || rx_n !== 3 || rx_log[2] !== {32'hC0C0_0002, 4'hF}) begin
      errors++;
      $display("FAIL oeabort_resume: popped=%0d last=%h timeout=%0b required 3/%h/0",
               rx_n, rx_log[2], to, {32'hC0C0_0002, 4'hF});
    end
  endtask

  task automatic test_grant_loss;
    int unsigned cap0;
    bit          to;
    rx_n = 0;
    cap0 = cap_n;
    for (int i = 0; i < 10; i++) put(32'hD0D0_0000 + 32'(i), 4'hF);
    wait_rd_low(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL gloss_start: rd_n=%b required 0 within 50 cycles", bus.oRD_N);
    end
    repeat (2) @(negedge clk);
    bus.iGRANT = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.oOE_N, bus.oRD_N} !== 2'b11 || cap_n - cap0 !== 3) begin
      errors++;
      $display("FAIL gloss_stop: oe/rd=%b captured=%0d required 11/3",
               {bus.oOE_N, bus.oRD_N}, cap_n - cap0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (cap_n - cap0 !== 3 || bus.oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL gloss_hold: captured=%0d busy=%b required 3/0", cap_n - cap0, bus.oBUSY);
    end
    bus.iGRANT = 1'b1;
    wait_drain(to);
    checks++;
    if (to || rx_n !== 10) begin
      errors++;
      $display("FAIL gloss_resume: popped=%0d timeout=%0b required 10/0", rx_n, to);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rx_log[i] !== {32'hD0D0_0000 + 32'(i), 4'hF}) begin
        errors++;
        $display("FAIL gloss_word[%0d]: got %h required %h", i, rx_log[i],
                 {32'hD0D0_0000 + 32'(i), 4'hF});
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] cnt0;
    int unsigned cap0;
    bit          to;
    rx_n = 0;
    cap0 = cap_n;
    cnt0 = bus.oRX_CNT;
    bus.iREADY = 1'b0;
    for (int i = 0; i < 40; i++) put(32'hB000_0000 + 32'(i), 4'hF);
    repeat (60) @(negedge clk);
    checks++;
    if (cap_n - cap0 !== 14 || rx_n !== 0) begin
      errors++;
      $display("FAIL bp_stall_fill: captured=%0d popped=%0d required 14/0", cap_n - cap0, rx_n);
    end
    checks++;
    if ({bus.oOE_N, bus.oBUSY, bus.oVALID} !== 3'b101) begin
      errors++;
      $display("FAIL bp_stall_ctrl: oe/busy/valid=%b required 101",
               {bus.oOE_N, bus.oBUSY, bus.oVALID});
    end
    checks++;
    if (bus.oDATA !== 32'hB000_0000) begin
      errors++;
      $display("FAIL bp_head: data=%h required b0000000", bus.oDATA);
    end
    bus.iREADY = 1'b1;
    wait_drain(to);
    checks++;
    if (to || rx_n !== 40 || 16'(bus.oRX_CNT - cnt0) !== 16'd40) begin
      errors++;
      $display("FAIL bp_total: popped=%0d rx_cnt_delta=%0d timeout=%0b required 40/40/0",
               rx_n, 16'(bus.oRX_CNT - cnt0), to);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (rx_log[i] !== {32'hB000_0000 + 32'(i), 4'hF}) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %h required %h", i, rx_log[i],
                 {32'hB000_0000 + 32'(i), 4'hF});
      end
    end
  endtask

  task automatic test_max_burst;
    int          lens [4];
    int          gaps [4];
    int          nb = 0;
    int          ng = 0;
    int          gap_run = 0;
    int unsigned cap_start = 0;
    bit          in_burst = 0;
    rx_n = 0;
    for (int i = 0; i < 20; i++) put(32'hE000_0000 + 32'(i), 4'hF);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!bus.oOE_N && !in_burst) begin
        in_burst  = 1;
        cap_start = cap_n;
        if (nb > 0 && ng < 4) begin
          gaps[ng] = gap_run;
          ng++;
        end
      end else if (bus.oOE_N && in_burst) begin
        in_burst = 0;
        if (nb < 4) lens[nb] = int'(cap_n - cap_start);
        nb++;
        gap_run = 1;
      end else if (bus.oOE_N) begin
        gap_run++;
      end
    end
    checks++;
    if (nb !== 3 || ng !== 2) begin
      errors++;
      $display("FAIL mb_bursts: bursts=%0d gaps=%0d required 3/2", nb, ng);
    end
    checks++;
    if (lens[0] !== 8 || lens[1] !== 8 || lens[2] !== 4) begin
      errors++;
      $display("FAIL mb_lengths: %0d/%0d/%0d required 8/8/4", lens[0], lens[1], lens[2]);
    end
    checks++;
    if (gaps[0] !== 2 || gaps[1] !== 2) begin
      errors++;
      $display("FAIL mb_gaps: %0d/%0d required 2/2", gaps[0], gaps[1]);
    end
    checks++;
    if (rx_n !== 20) begin
      errors++;
      $display("FAIL mb_count: popped=%0d required 20", rx_n);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (rx_log[i] !== {32'hE000_0000 + 32'(i), 4'hF}) begin
        errors++;
        $display("FAIL mb_word[%0d]: got %h required %h", i, rx_log[i],
                 {32'hE000_0000 + 32'(i), 4'hF});
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int unsigned first;
    bit          to;
    for (int i = 0; i < 10; i++) put(32'hF0F0_0000 + 32'(i), 4'hF);
    wait_rd_low(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rmid_start: rd_n=%b required 0 within 50 cycles", bus.oRD_N);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.oOE_N, bus.oRD_N, bus.oVALID, bus.oBUSY} !== 4'b1100 || bus.oRX_CNT !== 16'd0) begin
      errors++;
      $display("FAIL rmid_reset: oe/rd/valid/busy=%b rx_cnt=%0d required 1100/0",
               {bus.oOE_N, bus.oRD_N, bus.oVALID, bus.oBUSY}, bus.oRX_CNT);
    end
    rst   = 1'b0;
    rx_n  = 0;
    first = src_rd;
    wait_drain(to);
    checks++;
    if (to || rx_n !== src_wr - first || bus.oRX_CNT !== 16'(src_wr - first)) begin
      errors++;
      $display("FAIL rmid_fresh: popped=%0d rx_cnt=%0d timeout=%0b required %0d/%0d/0",
               rx_n, bus.oRX_CNT, to, src_wr - first, src_wr - first);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_log[i] !== src_mem[8'(first + i)]) begin
        errors++;
        $display("FAIL rmid_word[%0d]: got %h required %h", i, rx_log[i], src_mem[8'(first + i)]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.iGRANT = 1'b1;
    bus.iREADY = 1'b1;
    test_reset;
    test_single_burst;
    test_partial_be;
    test_grant_oe_abort;
    test_grant_loss;
    test_backpressure;
    test_max_burst;
    test_reset_mid_burst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
